register_file_sb: RTL and testbench

- Parametrised multi-word register file: DEPTH words of WIDTH bits, one write port, two read ports.
- Per-register busy scoreboard for in-flight producers, with a lock/acknowledge handshake.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Sits between the decode stage (reads operands, locks destinations) and writeback (writes results, releases locks).

---
 rtl/register_file_sb_if.sv | 32 +++
 rtl/register_file_sb.sv | 79 +++++++
 tb/tb_register_file_sb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/register_file_sb_if.sv
// Operand/result bus between decode/writeback and the scoreboarded register file.
// master = pipeline side, slave = register file.
interface register_file_sb_if #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned AW    = 3
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    ra_addr;
  logic [WIDTH-1:0] ra_data;
  logic             ra_busy;
  logic [AW-1:0]    rb_addr;
  logic [WIDTH-1:0] rb_data;
  logic             rb_busy;
  logic             lock_req;
  logic [AW-1:0]    lock_addr;
  logic             lock_ack;
  logic [DEPTH-1:0] busy_vec;

  modport master (
    output we, waddr, wdata, ra_addr, rb_addr, lock_req, lock_addr,
    input  ra_data, ra_busy, rb_data, rb_busy, lock_ack, busy_vec
  );

  modport slave (
    input  we, waddr, wdata, ra_addr, rb_addr, lock_req, lock_addr,
    output ra_data, ra_busy, rb_data, rb_busy, lock_ack, busy_vec
  );
endinterface

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with a per-register busy scoreboard,
// lock/ack handshake, optional hardwired-zero r0 and optional write bypass.
module register_file_sb #(
  parameter int unsigned WIDTH    = 20,
  parameter int unsigned AW       = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  register_file_sb_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wr_en;
  logic             lock_ack;

  assign wr_en = bus.we & ~(ZERO_REG && (bus.waddr == '0));

  // A write in the same cycle frees the register for the new requester.
  assign lock_ack = bus.lock_req
                  & (~busy_q[bus.lock_addr] | (bus.we & (bus.waddr == bus.lock_addr)))
                  & ~(ZERO_REG && (bus.lock_addr == '0));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[bus.waddr] = bus.wdata;
      busy_d[bus.waddr] = 1'b0;
    end
    // Applied last so a same-address lock wins over the write's release.
    if (lock_ack) begin
      busy_d[bus.lock_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    bus.ra_data = regs_q[bus.ra_addr];
    bus.ra_busy = busy_q[bus.ra_addr];
    if (ZERO_REG && (bus.ra_addr == '0)) begin
      bus.ra_data = '0;
      bus.ra_busy = 1'b0;
    end else if (BYPASS && bus.we && (bus.waddr == bus.ra_addr)) begin
      bus.ra_data = bus.wdata;
      bus.ra_busy = 1'b0;
    end
  end

  always_comb begin
    bus.rb_data = regs_q[bus.rb_addr];
    bus.rb_busy = busy_q[bus.rb_addr];
    if (ZERO_REG && (bus.rb_addr == '0)) begin
      bus.rb_data = '0;
      bus.rb_busy = 1'b0;
    end else if (BYPASS && bus.we && (bus.waddr == bus.rb_addr)) begin
      bus.rb_data = bus.wdata;
      bus.rb_busy = 1'b0;
    end
  end

  assign bus.lock_ack = lock_ack;
  assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_register_file_sb.sv
// Checks a bypassing and a non-bypassing register_file_sb against a reference model
// with directed scenarios, async reset pulses and random traffic.
module tb_register_file_sb;
  localparam int unsigned WIDTH = 20;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             we, lock_req;
  logic [AW-1:0]    waddr, ra_addr, rb_addr, lock_addr;
  logic [WIDTH-1:0] wdata;

  register_file_sb_if #(.WIDTH(WIDTH), .AW(AW)) bus_b ();
  register_file_sb_if #(.WIDTH(WIDTH), .AW(AW)) bus_n ();

  assign bus_b.we = we;        assign bus_n.we = we;
  assign bus_b.waddr = waddr;  assign bus_n.waddr = waddr;
  assign bus_b.wdata = wdata;  assign bus_n.wdata = wdata;
  assign bus_b.ra_addr = ra_addr;  assign bus_n.ra_addr = ra_addr;
  assign bus_b.rb_addr = rb_addr;  assign bus_n.rb_addr = rb_addr;
  assign bus_b.lock_req = lock_req;    assign bus_n.lock_req = lock_req;
  assign bus_b.lock_addr = lock_addr;  assign bus_n.lock_addr = lock_addr;

  register_file_sb #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  register_file_sb #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nobyp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain array of values and a set of owned registers.
  int unsigned m_val  [DEPTH];
  bit          m_owned[DEPTH];

  function automatic void m_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_val[i]   = 0;
      m_owned[i] = 0;
    end
  endfunction

  function automatic int unsigned m_read(input int unsigned a, input bit byp);
    if (a == 0) return 0;
    if (byp && we && int'(waddr) == int'(a)) return int'(wdata);
    return m_val[a];
  endfunction

  function automatic bit m_busy(input int unsigned a, input bit byp);
    if (a == 0) return 0;
    if (byp && we && int'(waddr) == int'(a)) return 0;
    return m_owned[a];
  endfunction

  function automatic bit m_ack();
    if (!lock_req || lock_addr == 0) return 0;
    if (we && waddr == lock_addr) return 1;
    return !m_owned[lock_addr];
  endfunction

  function automatic int unsigned m_vec();
    int unsigned v = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (m_owned[i]) v += (1 << i);
    return v;
  endfunction

  task automatic check_all();
    check("byp_ra_data", 32'(bus_b.ra_data), m_read(int'(ra_addr), 1));
    check("byp_rb_data", 32'(bus_b.rb_data), m_read(int'(rb_addr), 1));
    check("byp_ra_busy", 32'(bus_b.ra_busy), 32'(m_busy(int'(ra_addr), 1)));
    check("byp_rb_busy", 32'(bus_b.rb_busy), 32'(m_busy(int'(rb_addr), 1)));
    check("byp_lock_ack", 32'(bus_b.lock_ack), 32'(m_ack()));
    check("byp_busy_vec", 32'(bus_b.busy_vec), m_vec());
    check("nob_ra_data", 32'(bus_n.ra_data), m_read(int'(ra_addr), 0));
    check("nob_rb_data", 32'(bus_n.rb_data), m_read(int'(rb_addr), 0));
    check("nob_ra_busy", 32'(bus_n.ra_busy), 32'(m_busy(int'(ra_addr), 0)));
    check("nob_rb_busy", 32'(bus_n.rb_busy), 32'(m_busy(int'(rb_addr), 0)));
    check("nob_lock_ack", 32'(bus_n.lock_ack), 32'(m_ack()));
    check("nob_busy_vec", 32'(bus_n.busy_vec), m_vec());
  endtask

  task automatic drive(input bit w, input int wa, input int wd, input int ra, input int rb,
                       input bit lr, input int la);
    we = w; waddr = AW'(wa); wdata = WIDTH'(wd);
    ra_addr = AW'(ra); rb_addr = AW'(rb);
    lock_req = lr; lock_addr = AW'(la);
    #1;
    check_all();
  endtask

  task automatic tick();
    bit ack;
    @(posedge clk);
    ack = m_ack();
    if (we && waddr != 0) begin
      m_val[waddr]   = int'(wdata);
      m_owned[waddr] = 0;
    end
    if (ack) m_owned[lock_addr] = 1;
    #1;
  endtask

  task automatic async_reset_pulse();
    #1 rst_n = 1'b0;
    #1 m_reset();
    check_all();
    check("rst_busy_vec", 32'(bus_b.busy_vec), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    we = 0; waddr = 0; wdata = 0; ra_addr = 0; rb_addr = 0; lock_req = 0; lock_addr = 0;
    #2 check_all();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic write then dual read of the same register.
    drive(1, 3, 'hABCDE, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 3, 3, 0, 0);
    check("rd3_a", 32'(bus_b.ra_data), 32'hABCDE);
    check("rd3_b", 32'(bus_n.rb_data), 32'hABCDE);
    tick();

    // Hardwired zero: write and lock on r0 ignored.
    drive(1, 0, 'hFFFFF, 0, 0, 1, 0);
    check("r0_ack", 32'(bus_b.lock_ack), 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("r0_rd", 32'(bus_b.ra_data), 32'h0);
    check("r0_busy", 32'(bus_b.busy_vec), 32'h0);
    tick();

    // Bypass versus no bypass.
    drive(1, 5, 1, 0, 0, 0, 0); tick();
    drive(1, 5, 'h12345, 5, 0, 0, 0);
    check("byp_fwd", 32'(bus_b.ra_data), 32'h12345);
    check("nob_old", 32'(bus_n.ra_data), 32'h1);
    tick();
    drive(0, 0, 0, 5, 0, 0, 0);
    check("nob_new", 32'(bus_n.ra_data), 32'h12345);
    tick();

    // Lock stall on r2, then write frees it for the waiting requester.
    drive(0, 0, 0, 2, 0, 1, 2);
    check("lk2_ack", 32'(bus_b.lock_ack), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 2, 0, 1, 2);
      check("lk2_stall", 32'(bus_b.lock_ack), 32'h0);
      check("lk2_vec", 32'(bus_b.busy_vec), 32'h04);
      check("lk2_rbusy", 32'(bus_n.ra_busy), 32'h1);
      tick();
    end
    drive(1, 2, 'h777, 0, 0, 1, 2);
    check("lk2_wr_ack", 32'(bus_b.lock_ack), 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("lk2_held", 32'(bus_b.busy_vec), 32'h04);
    tick();

    // Release r6 by write; also release r2.
    drive(0, 0, 0, 0, 0, 1, 6); tick();
    drive(1, 6, 'h00042, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 6, 0, 0);
    check("rel6_busy", 32'(bus_b.rb_busy), 32'h0);
    check("rel6_data", 32'(bus_b.rb_data), 32'h00042);
    tick();
    drive(1, 2, 'h1, 0, 0, 0, 0); tick();

    // Reset with locks pending on 1, 4, 7.
    drive(0, 0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 4); tick();
    drive(0, 0, 0, 4, 7, 1, 7); tick();
    drive(0, 0, 0, 3, 5, 0, 0);
    check("pend_vec", 32'(bus_b.busy_vec), 32'h92);
    async_reset_pulse();
    drive(0, 0, 0, 3, 5, 0, 0);
    tick();

    // Random traffic with occasional async resets.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 20'hFFFFF)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0),
            int'($urandom_range(0, 7)));
      if ($urandom_range(0, 49) == 0) async_reset_pulse();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
